ram_burst_reader: RTL
=====================

Name: ram_burst_reader

Overview:
- Downstream consumer of the single-port feature-map RAM (registered read, 1-cycle latency).
- On a start command, reads len consecutive words from base_addr, with address wrap-around.
- Emits the words as a valid/ready stream toward the convolution datapath.
- A 2-entry skid FIFO absorbs the RAM read latency under backpressure, so no word is lost or duplicated.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 6, RAM address width (depth 2**ADDR_WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first address, sampled with start
- len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH, sampled with start
- busy  out  1  high while a burst is in progress
- done  out  1  one-cycle pulse after the last word is accepted downstream
- ram_addr  out  ADDR_WIDTH  address to the RAM; driven directly from the internal address register
- ram_q  in  DATA_WIDTH  RAM read data; corresponds to ram_addr of the previous cycle
- m_data  out  DATA_WIDTH  stream data (FIFO head)
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from consumer

Behaviour:
- Reset: when rst_n=0 at a clk edge, the block returns to IDLE and clears all state.
  - Post-reset outputs: busy=0, done=0, m_valid=0, m_data=0, ram_addr=0.
  - FIFO count=0, in-flight flag=0, issue and pop counters=0.
  - Reset mid-burst aborts the burst with no done pulse.
- States: IDLE, READ, DRAIN.
  - IDLE & start & len!=0 -> READ: addr_reg<=base_addr, issue_left<=len, pop_left<=len, busy<=1.
  - IDLE & start & len==0 -> stays IDLE; done pulses the next cycle; busy stays 0; no stream output.
  - READ -> DRAIN: when the final issue occurs (issue_left reaches 0).
  - DRAIN -> IDLE: on the handshake that makes pop_left reach 0. done=1 and busy=0 on the following cycle.
  - start outside IDLE is ignored.
- Issue rule:
  - pop = m_valid & m_ready.
  - An issue occurs in a READ cycle when (fifo_count + inflight - pop) < 2.
  - On issue: addr_reg <= addr_reg+1, modulo 2**ADDR_WIDTH (wrap 2**ADDR_WIDTH-1 -> 0); issue_left decrements; inflight<=1 for the next cycle. Otherwise inflight<=0.
  - The RAM reads every cycle; only issued cycles are captured.
- Capture: in a cycle with inflight=1, ram_q is written into the FIFO tail at the closing edge.
- Latency: start accepted at edge E0 -> first RAM read in cycle after E0 -> m_valid=1 two cycles after E0.
- Throughput: with m_ready held 1, one word per cycle after the initial latency.
- Burst timing: a burst of N words with no backpressure asserts done N+2 cycles after the start cycle.
- FIFO behaviour:
  - Depth 2; m_valid = (fifo_count!=0).
  - Simultaneous push and pop keeps the count unchanged, and data order is preserved.
  - The FIFO never overflows, by the issue rule.
  - m_data holds stable while m_valid=1 and m_ready=0.
- Ordering: words are emitted strictly in address order base_addr, base_addr+1, ... with wrap-around.
- Width rules:
  - issue_left and pop_left are ADDR_WIDTH+1 bits.
  - len=2**ADDR_WIDTH reads every location exactly once.
- After done, ram_addr holds the last addr_reg value (base+len, wrapped) until the next start.

Test Plan:
- Preload ram[i]=i+0x10, base=4, len=5, m_ready=1 -> m_data 0x14..0x18 on 5 consecutive cycles, m_valid first 2 cycles after start, done 7 cycles after start cycle.
- Wrap: ADDR_WIDTH=6, base=62, len=4 -> stream ram[62], ram[63], ram[0], ram[1]; final ram_addr=2.
- Backpressure: len=8, m_ready toggles 1,0,0,1,0,1... -> all 8 words in order, none duplicated; m_data stable while stalled; FIFO count never exceeds 2.
- len=0 start -> done pulse next cycle, m_valid never 1, busy stays 0; len=64 (full depth) -> 64 words ram[base..] wrapping, then done.
- Start pulsed again during READ -> ignored; current burst completes unchanged; new start after done accepted.
- rst_n=0 for one cycle mid-burst (after 3 of 8 words) -> next cycle m_valid=0, busy=0, no done; a subsequent burst runs correctly from its own base.

Source files
------------

// File: rtl/ram_burst_reader_if.sv
// Command, RAM-read and output-stream signals of the feature-map burst reader.
// The master modport is the reader's view; slave is the environment's view.
interface ram_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   len;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  start, base_addr, len, ram_q, m_ready,
    output busy, done, ram_addr, m_data, m_valid
  );

  modport slave (
    output start, base_addr, len, ram_q, m_ready,
    input  busy, done, ram_addr, m_data, m_valid
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Streams len words from base_addr (wrapping) out of a 1-cycle-latency RAM; first m_valid 2 edges after start.
// Backpressure: a 2-entry skid FIFO plus an issue throttle keep every word exactly once under m_ready stalls.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_burst_reader_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
  logic [ADDR_WIDTH:0]   pop_left_q, pop_left_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic                  done_q, done_d;

  logic                  pop;
  logic                  issue;
  logic [2:0]            occupancy;

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.ram_addr = addr_q;
  assign bus.m_data   = slot0_q;
  assign bus.m_valid  = (count_q != 2'd0);

  assign pop = bus.m_valid & bus.m_ready;
  // Words held or on their way, after this cycle's pop; pop implies count_q >= 1.
  assign occupancy = {1'b0, count_q} + 3'(inflight_q) - 3'(pop);
  assign issue     = (state_q == READ) && (occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      slot0_q      <= '0;
      slot1_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    inflight_d   = issue;
    count_d      = count_q;
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_d      = READ;
            addr_d       = bus.base_addr;
            issue_left_d = bus.len;
            pop_left_d   = bus.len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d       = addr_q + ADDR_ONE;
          issue_left_d = issue_left_q - CNT_ONE;
          if (issue_left_q == CNT_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      default: ;
    endcase

    if (pop) begin
      pop_left_d = pop_left_q - CNT_ONE;
      if (state_q == DRAIN && pop_left_q == CNT_ONE) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    // slot0 is the head; a push with count 2 cannot occur because of the issue throttle.
    case ({inflight_q, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = bus.ram_q;
        else                 slot1_d = bus.ram_q;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = bus.ram_q;
        end else begin
          slot0_d = slot1_q;
          slot1_d = bus.ram_q;
        end
      end
      default: ;
    endcase
  end

endmodule
